fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single FIFO write port (Wr_enable/data_in) among NUM_REQ producers. It grants one producer at a time for a bounded burst, muxes that producer's data onto the FIFO write bus, and applies backpressure from the FIFO full flag. It sits directly upstream of the FIFO; the FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_WIDTH, 8, FIFO data width
MAX_BURST, 4, maximum writes per grant (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-producer write request, level, held until data accepted
req_data  input  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
full  input  1  FIFO full flag
gnt  output  NUM_REQ  one-hot grant; data of producer i accepted in any cycle where req[i] && gnt[i]
Wr_enable  output  1  FIFO write strobe
data_in  output  DATA_WIDTH  FIFO write data
owner_id  output  $clog2(NUM_REQ)  current/last owner index
busy  output  1  high while in BURST state

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, owner_id=0, burst_cnt=0; gnt=0, Wr_enable=0, busy=0, data_in=0.
- FSM states: IDLE, BURST.
- IDLE: if any req bit set, select the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ. Register owner_id and clear burst_cnt; next state BURST. With no req, stay in IDLE. gnt=0 throughout IDLE, so each grant costs a 1-cycle arbitration bubble.
- BURST, combinational outputs from registered state:
  - gnt[owner_id] = !full; all other gnt bits are 0.
  - Wr_enable = req[owner_id] && !full.
  - data_in = req_data slice of owner_id when Wr_enable=1, otherwise 0.
- BURST, sequential:
  - Write cycle (Wr_enable=1): burst_cnt increments. If the new count equals MAX_BURST, release.
  - full=1: stall. No write, burst_cnt is held, owner is kept (no release on full).
  - req[owner_id]=0 in a BURST cycle: no write, release.
- Release: next state IDLE, rr_ptr = (owner_id+1) mod NUM_REQ, owner_id holds its value.
- Write rate: at most one write per cycle. Wr_enable is never asserted while full=1.
- No req bit is ever granted without a prior IDLE arbitration cycle.
- Fairness: with all NUM_REQ requesting continuously and the FIFO never full, every producer is granted once per NUM_REQ grants.
- Width rule: burst_cnt is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST (cannot wrap).
- Reset asserted mid-burst: outputs go to reset values immediately. The partially written burst is not resumed.

Optional Feature:
Macro FIFO_ARB_LOCK_EN.
- Defined: adds input lock [NUM_REQ]. In BURST, while lock[owner_id]=1, the MAX_BURST release is suppressed and burst_cnt saturates. Release occurs only when req[owner_id] drops, or on the first write cycle with lock[owner_id]=0 and burst_cnt>=MAX_BURST.
- Undefined: no lock port; the burst limit is always enforced.

Test Plan:
1. Single producer: req=4'b0100 continuously, data 0x10,0x11,..., full=0 -> one IDLE cycle, then 4 writes 0x10..0x13 with gnt=4'b0100. Repeats with one bubble every 4 writes.
2. All producers: req=4'b1111 after reset -> owner_id order 0,1,2,3,0. Each owner gets 4 writes; Wr_enable=0 on each IDLE cycle.
3. Full backpressure: owner 1, full=1 after 2 writes, held 5 cycles -> gnt=0 and Wr_enable=0 for 5 cycles. Burst then resumes and completes 2 more writes, 4 total.
4. Early drop: owner 2 deasserts req after 1 write, req=4'b1001 pending -> release. Next owner is 3 (rr_ptr=3), then 0.
5. Reset mid-burst: reset pulses after owner 3's 2nd write -> gnt=0, Wr_enable=0, busy=0 immediately. After release with req=4'b1111, the first owner is 0.
6. (FIFO_ARB_LOCK_EN) owner 0 with lock[0]=1 for 10 writes -> 10 consecutive writes, no release. lock[0] drops -> release after the next write.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one FIFO write port among
//            NUM_REQ producers, with FIFO-full backpressure.
// Options  : FIFO_ARB_LOCK_EN adds a per-producer lock input that extends a
//            burst past MAX_BURST.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          Wr_enable,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           w_any;
    logic [IDW-1:0] w_pick;
    logic           w_lock_own;
    logic           w_release;

`ifdef FIFO_ARB_LOCK_EN
    assign w_lock_own = lock[owner_q];
`else
    assign w_lock_own = 1'b0;
`endif

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        w_any  = 1'b0;
        w_pick = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                w_any  = 1'b1;
                w_pick = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt       = '0;
        Wr_enable = 1'b0;
        data_in   = '0;
        w_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    owner_d = w_pick;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                gnt[owner_q] = !full;
                Wr_enable    = req[owner_q] && !full;
                if (Wr_enable) begin
                    data_in = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
                end
                if (!req[owner_q]) begin
                    w_release = 1'b1;
                end else if (!full) begin
                    // Saturating count: a locked burst can run past MAX_BURST.
                    if (cnt_q != CW'(MAX_BURST)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if ((cnt_d == CW'(MAX_BURST)) && !w_lock_own) begin
                        w_release = 1'b1;
                    end
                end
                if (w_release) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    assign owner_id = owner_q;
    assign busy     = (state_q == BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed scoreboard bench for fifo_wr_arbiter (NUM_REQ=4,
//            DATA_WIDTH=8, MAX_BURST=4); lock scenario under FIFO_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic             full;
`ifdef FIFO_ARB_LOCK_EN
    logic [NR-1:0]    lock;
`endif
    logic [NR-1:0]    gnt;
    logic             Wr_enable;
    logic [DW-1:0]    data_in;
    logic [1:0]       owner_id;
    logic             busy;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .full      (full),
`ifdef FIFO_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .Wr_enable (Wr_enable),
        .data_in   (data_in),
        .owner_id  (owner_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         owner;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pdata [NR];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdata[i];
    endtask

    task automatic push_burst(input int owner, input logic [7:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.owner = owner;
            e.data  = base + 8'(i);
            sb.push_back(e);
        end
    endtask

    // One clock: sample at negedge, score any write, advance producers on accept.
    task automatic cycle(input int exp_we);
        exp_t e;
        @(negedge clk);
        if (exp_we >= 0) check("wr_enable", 32'(Wr_enable), 32'(exp_we));
        if (full) check("we_while_full", 32'(Wr_enable), 32'd0);
        if (Wr_enable) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("wdata", 32'(data_in), 32'(e.data));
                check("owner", 32'(owner_id), 32'(e.owner));
                check("gnt", 32'(gnt), 32'(1 << e.owner));
            end
        end
        for (int i = 0; i < NR; i++) if (req[i] && gnt[i]) pdata[i] = pdata[i] + 8'd1;
        @(posedge clk);
        #1;
        drive_data();
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        full  = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
        lock  = '0;
`endif
        for (int i = 0; i < NR; i++) pdata[i] = 8'h00;
        drive_data();
        #2 reset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_we", 32'(Wr_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data_in), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: single producer, bursts of four separated by one bubble
        pdata[2] = 8'h10;
        drive_data();
        req = 4'b0100;
        push_burst(2, 8'h10, 8);
        for (int c = 0; c < 10; c++) cycle((c == 0 || c == 5) ? 0 : 1);
        req = '0;
        cycle(0);
        check("t1_sb_drained", 32'(sb.size()), 32'd0);

        // 2: all request after reset, owners 0,1,2,3,0
        reset = 1'b1;
        #1;
        check("t2_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < NR; i++) pdata[i] = 8'h40 + 8'(16 * i);
        drive_data();
        req = 4'b1111;
        push_burst(0, 8'h40, 4);
        push_burst(1, 8'h50, 4);
        push_burst(2, 8'h60, 4);
        push_burst(3, 8'h70, 4);
        push_burst(0, 8'h44, 4);
        for (int c = 0; c < 25; c++) cycle((c % 5 == 0) ? 0 : 1);
        req = '0;
        check("t2_sb_drained", 32'(sb.size()), 32'd0);

        // 3: owner 1 stalled by full for five cycles mid-burst
        req = 4'b0010;
        push_burst(1, pdata[1], 4);
        cycle(0);
        cycle(1);
        cycle(1);
        full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t3_gnt_full", 32'(gnt), 32'd0);
            check("t3_busy_full", 32'(busy), 32'd1);
            cycle(0);
        end
        full = 1'b0;
        #1;
        check("t3_gnt_resume", 32'(gnt), 32'b0010);
        cycle(1);
        cycle(1);
        req = '0;
        cycle(0);
        check("t3_busy_after", 32'(busy), 32'd0);
        check("t3_sb_drained", 32'(sb.size()), 32'd0);

        // 4: owner 2 drops after one write, 3 then 0 follow
        req = 4'b1101;
        push_burst(2, pdata[2], 1);
        push_burst(3, pdata[3], 4);
        push_burst(0, pdata[0], 4);
        cycle(0);
        cycle(1);
        req = 4'b1001;
        cycle(0);
        cycle(0);
        for (int c = 0; c < 4; c++) cycle(1);
        cycle(0);
        for (int c = 0; c < 4; c++) cycle(1);
        req = '0;
        check("t4_sb_drained", 32'(sb.size()), 32'd0);

        // 5: reset after owner 3's second write
        req = 4'b1000;
        push_burst(3, pdata[3], 2);
        cycle(0);
        cycle(1);
        cycle(1);
        check("t5_owner_pre", 32'(owner_id), 32'd3);
        reset = 1'b1;
        #1;
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_we", 32'(Wr_enable), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_owner", 32'(owner_id), 32'd0);
        cycle(0);
        reset = 1'b0;
        req = 4'b1111;
        push_burst(0, pdata[0], 4);
        cycle(0);
        for (int c = 0; c < 4; c++) cycle(1);
        req = '0;
        cycle(0);
        check("t5_sb_drained", 32'(sb.size()), 32'd0);

`ifdef FIFO_ARB_LOCK_EN
        // 6: lock holds owner 0 for ten writes, released after the next one
        lock = 4'b0001;
        req  = 4'b0001;
        push_burst(0, pdata[0], 11);
        cycle(0);
        for (int c = 0; c < 10; c++) cycle(1);
        check("t6_busy_locked", 32'(busy), 32'd1);
        lock = '0;
        cycle(1);
        check("t6_busy_released", 32'(busy), 32'd0);
        cycle(0);
        req = '0;
        check("t6_sb_drained", 32'(sb.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
